// File: rtl/gpu_ctrl_pkg.sv
// Shared types and constants for the 2D GPU shape sequencer.
package gpu_ctrl_pkg;

    typedef enum logic [1:0] {
        LINE    = 2'd0,
        POLYGON = 2'd1,
        CIRCLE  = 2'd2,
        RSVD    = 2'd3
    } shape_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        START  = 3'd2,
        RUN    = 3'd3,
        PUSH   = 3'd4,
        NEXT   = 3'd5,
        DONE   = 3'd6
    } seq_state_t;

    localparam logic PRIM_LINE = 1'b0;
    localparam logic PRIM_ARC  = 1'b1;

endpackage

// File: rtl/shape_sequencer_if.sv
// Command, primitive-engine and Avalon write bundle for the shape sequencer.
interface shape_sequencer_if #(
    parameter int PIX_W = 32,
    parameter int CNT_W = 16,
    parameter int IDX_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_shape;
    logic [IDX_W:0]   cmd_nverts;
    logic             prim_start;
    logic             prim_mode;
    logic [IDX_W-1:0] prim_sel;
    logic             prim_last;
    logic             prim_pix_valid;
    logic [PIX_W-1:0] prim_pix_data;
    logic             prim_pix_ready;
    logic             prim_done;
    logic             avm_write;
    logic [PIX_W-1:0] avm_writedata;
    logic             avm_waitrequest;
    logic             shapedone;
    logic             err_badshape;
    logic             busy;
    logic [CNT_W-1:0] pix_count;

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_shape, cmd_nverts,
        input  prim_pix_valid, prim_pix_data, prim_done, avm_waitrequest,
        output cmd_ready, prim_start, prim_mode, prim_sel, prim_last,
        output prim_pix_ready, avm_write, avm_writedata,
        output shapedone, err_badshape, busy, pix_count
    );

    // Environment side: command source, engine and memory
    modport master (
        output cmd_valid, cmd_shape, cmd_nverts,
        output prim_pix_valid, prim_pix_data, prim_done, avm_waitrequest,
        input  cmd_ready, prim_start, prim_mode, prim_sel, prim_last,
        input  prim_pix_ready, avm_write, avm_writedata,
        input  shapedone, err_badshape, busy, pix_count
    );
endinterface

// File: rtl/shape_sequencer_pix_write_port.sv
// Single-entry pixel holding register feeding the Avalon-MM write port.
module pix_write_port #(
    parameter int PIX_W = 32
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             load,
    input  logic [PIX_W-1:0] load_data,
    input  logic             avm_waitrequest,
    output logic             avm_write,
    output logic [PIX_W-1:0] avm_writedata,
    output logic             accepted
);
    logic             full;
    logic [PIX_W-1:0] data;

    // Hold the pixel until the slave stops stalling; reset drops the request at once
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            full <= 1'b0;
            data <= '0;
        end else if (load) begin
            full <= 1'b1;
            data <= load_data;
        end else if (full && !avm_waitrequest) begin
            full <= 1'b0;
        end
    end

    assign avm_write     = full;
    assign avm_writedata = data;
    assign accepted      = full & ~avm_waitrequest;
endmodule

// File: rtl/shape_sequencer.sv
// Shape command sequencer: steps the primitive engine through edges/octants
// and forwards each generated pixel to the frame-buffer write port.
module shape_sequencer
    import gpu_ctrl_pkg::*;
#(
    parameter int MAX_VERTS = 8,
    parameter int ARC_COUNT = 8,
    parameter int PIX_W     = 32,
    parameter int CNT_W     = 16,
    parameter int IDX_W     = $clog2(MAX_VERTS > ARC_COUNT ? MAX_VERTS : ARC_COUNT)
) (
    input logic               clk,
    input logic               nreset,
    shape_sequencer_if.slave  bus
);
    localparam logic [IDX_W:0] MAXV = (IDX_W+1)'(MAX_VERTS);
    localparam logic [IDX_W:0] ARCS = (IDX_W+1)'(ARC_COUNT);
    localparam logic [IDX_W:0] MINV = (IDX_W+1)'(3);

    seq_state_t       state;
    shape_t           shape_q;
    logic [IDX_W:0]   nverts_q;
    logic [IDX_W:0]   total;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] pix_cnt;
    logic             done_pend;
    logic             bad_cmd;
    logic             is_last;
    logic             prim_active;
    logic             wr_load;
    logic             wr_accepted;

    assign bad_cmd = (shape_q == RSVD) ||
                     ((shape_q == POLYGON) && ((nverts_q < MINV) || (nverts_q > MAXV)));
    assign is_last = ({1'b0, idx} == (total - 1'b1));
    assign wr_load = (state == RUN) && bus.prim_pix_valid;

    // Sequencer FSM with shape, index and pixel-count registers
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= IDLE;
            shape_q   <= LINE;
            nverts_q  <= '0;
            total     <= '0;
            idx       <= '0;
            pix_cnt   <= '0;
            done_pend <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        shape_q   <= shape_t'(bus.cmd_shape);
                        nverts_q  <= bus.cmd_nverts;
                        pix_cnt   <= '0;
                        idx       <= '0;
                        done_pend <= 1'b0;
                        state     <= DECODE;
                    end
                end
                DECODE: begin
                    if (bad_cmd) begin
                        state <= IDLE;
                    end else begin
                        case (shape_q)
                            LINE:    total <= (IDX_W+1)'(1);
                            POLYGON: total <= nverts_q;
                            default: total <= ARCS;
                        endcase
                        state <= START;
                    end
                end
                START: state <= RUN;
                RUN: begin
                    if (bus.prim_pix_valid) begin
                        // A done arriving with the last pixel is remembered until the write lands
                        done_pend <= bus.prim_done;
                        state     <= PUSH;
                    end else if (bus.prim_done) begin
                        state <= NEXT;
                    end
                end
                PUSH: begin
                    if (bus.prim_done) done_pend <= 1'b1;
                    if (wr_accepted) begin
                        if (pix_cnt != '1) pix_cnt <= pix_cnt + 1'b1;
                        if (done_pend || bus.prim_done) begin
                            done_pend <= 1'b0;
                            state     <= NEXT;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                NEXT: begin
                    if (is_last) begin
                        state <= DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= START;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign prim_active = (state == START) || (state == RUN) ||
                         (state == PUSH)  || (state == NEXT);

    assign bus.cmd_ready      = (state == IDLE);
    assign bus.busy           = (state != IDLE);
    assign bus.prim_start     = (state == START);
    assign bus.prim_mode      = prim_active && (shape_q == CIRCLE) ? PRIM_ARC : PRIM_LINE;
    assign bus.prim_sel       = prim_active ? idx : '0;
    assign bus.prim_last      = prim_active && is_last;
    assign bus.prim_pix_ready = (state == RUN);
    assign bus.shapedone      = (state == DONE);
    assign bus.err_badshape   = (state == DECODE) && bad_cmd;
    assign bus.pix_count      = pix_cnt;

    pix_write_port #(
        .PIX_W (PIX_W)
    ) u_wr (
        .clk             (clk),
        .nreset          (nreset),
        .load            (wr_load),
        .load_data       (bus.prim_pix_data),
        .avm_waitrequest (bus.avm_waitrequest),
        .avm_write       (bus.avm_write),
        .avm_writedata   (bus.avm_writedata),
        .accepted        (wr_accepted)
    );
endmodule

// File: doc/shape_sequencer.md
Name: shape_sequencer

Overview:
Parametrised successor to the core control unit of the 2D GPU. It accepts one shape command at a time: a line, an N-vertex closed polygon or a circle. It then sequences the primitive engine through each edge or octant, and forwards every generated pixel to the frame-buffer Avalon-MM write port while honouring waitrequest. It sits between the command FIFO and the primitive engine / memory interface.

Parameters:
MAX_VERTS, 8, maximum polygon vertex count (must be at least 3)
ARC_COUNT, 8, arcs per circle (octants)
PIX_W, 32, pixel word width (address and colour packed by the engine)
CNT_W, 16, width of the per-shape pixel counter
IDX_W, $clog2(MAX_VERTS > ARC_COUNT ? MAX_VERTS : ARC_COUNT), primitive index width (derived)

Ports:
clk  in  1  system clock
nreset  in  1  asynchronous active-low reset
cmd_valid  in  1  shape command present
cmd_ready  out  1  block accepts command (IDLE only)
cmd_shape  in  2  0=line, 1=polygon, 2=circle, 3=reserved
cmd_nverts  in  IDX_W+1  polygon vertex count (ignored otherwise)
prim_start  out  1  one-cycle start pulse to primitive engine
prim_mode  out  1  0=line segment, 1=arc
prim_sel  out  IDX_W  edge or octant index of current primitive
prim_last  out  1  current primitive is the final one of the shape
prim_pix_valid  in  1  engine has a pixel
prim_pix_data  in  PIX_W  engine pixel word
prim_pix_ready  out  1  pixel accepted this cycle
prim_done  in  1  engine finished current primitive
avm_write  out  1  Avalon write request
avm_writedata  out  PIX_W  pixel word
avm_waitrequest  in  1  Avalon stall
shapedone  out  1  one-cycle pulse when shape complete
err_badshape  out  1  one-cycle pulse on rejected command
busy  out  1  high in every state except IDLE
pix_count  out  CNT_W  pixels written for current or last shape

Behaviour:
- Reset (async, nreset low): state IDLE, all counters and registers 0, all outputs 0 except cmd_ready=1. Outputs are Moore-decoded from state plus registers. Reset mid-shape aborts immediately; avm_write drops asynchronously.
- FSM states: IDLE, DECODE, START, RUN, PUSH, NEXT, DONE.
- IDLE: cmd_ready=1. On cmd_valid, latch shape and nverts, clear pix_count and idx, go to DECODE.
- DECODE: the block rejects the command if shape==3, or if polygon nverts<3 or nverts>MAX_VERTS. On rejection: err_badshape=1 for this cycle, then IDLE.
- DECODE, valid command: set total=1 (line), nverts (polygon) or ARC_COUNT (circle), then go to START.
- START: prim_start=1, prim_sel=idx, prim_mode=(shape==circle), prim_last=(idx==total-1); go to RUN. prim_sel, prim_mode and prim_last hold stable from START through NEXT.
- RUN: prim_pix_ready=1.
  - prim_pix_valid: capture data into the output register, go to PUSH.
  - prim_done with no valid: go to NEXT.
  - Valid and done in the same cycle: capture the pixel, set done_pend, go to PUSH.
- PUSH: avm_write=1, avm_writedata held constant. Stay while avm_waitrequest=1. When waitrequest=0, pix_count increments (saturating at all-ones), then go to NEXT if done_pend (clearing it), else RUN.
- NEXT: if idx==total-1 go to DONE, else idx+1 and go to START.
- DONE: shapedone=1 for one cycle, then IDLE. pix_count holds until the next accepted command.
- Latency:
  - Command accept edge to prim_start high: 2 cycles.
  - Pixel capture to avm_write high: 1 cycle.
  - Minimum 2 cycles per pixel with waitrequest low.
- prim_pix_valid outside RUN is ignored: prim_pix_ready=0, and the engine must hold the pixel. prim_done outside RUN/PUSH is ignored.
- cmd_valid while busy: not accepted; cmd_ready=0.

Decomposition:
- Package gpu_ctrl_pkg holds:
  - shape_t enum (LINE, POLYGON, CIRCLE, RSVD)
  - seq_state_t enum
  - PRIM_LINE / PRIM_ARC constants
- One natural sub-module, pix_write_port: a single-entry holding register driving avm_write/avm_writedata until waitrequest clears, with a "accepted" pulse back to the FSM.
- Counters (idx, pix_count) stay in the top module.

Test Plan:
- Line: cmd_shape=0; engine gives 3 pixels then done; waitrequest=0 -> 3 avm writes with matching data, pix_count=3, one shapedone, prim_start seen once with prim_sel=0 and prim_last=1.
- Polygon nverts=4: each edge gives 1 pixel -> prim_sel sequence 0,1,2,3, prim_last only on 3, 4 writes, shapedone once.
- Circle with waitrequest held 3 cycles per write: 8 arcs × 2 pixels -> 16 writes, avm_writedata stable during every stall, prim_mode=1, pix_count=16.
- Bad commands (polygon nverts=2, nverts=9, shape=3) -> err_badshape pulse 1 cycle after accept, no prim_start, back to IDLE with cmd_ready=1.
- Pixel and prim_done asserted together on the last line pixel -> pixel written, then NEXT; no pixel lost, no extra prim_start.
- nreset low during a PUSH stall of a circle -> avm_write=0 immediately; after release, cmd_ready=1 and pix_count=0, and a new line command completes normally.
